// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter; bytes queue in a small FIFO and go out
// back-to-back on TX (start, 8 data bits LSB-first, stop) at BAUD_DIV clk per bit.
module uart_tx #(
  parameter int BAUD_DIV = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       full,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       TX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic {IDLE, TRANSMIT} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [9:0] sh;
  logic [CW-1:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic push, shift, frame_end, load;
  // a new frame loads straight after the stop bit, so queued bytes leave with no idle gap
  always_comb begin
    full = cnt == (AW+1)'(FIFO_DEPTH);
    push = trmt & ~full;
    shift = state == TRANSMIT && baud_cnt == CW'(BAUD_DIV - 1);
    frame_end = shift && bit_cnt == 4'd9;
    load = cnt != '0 && (state != TRANSMIT || frame_end);
    tx_busy = state == TRANSMIT;
    TX = sh[0];
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= tx_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      sh <= '1;
      baud_cnt <= '0;
      bit_cnt <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= frame_end;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
      if (load) begin
        sh <= {1'b1, mem[rd_ptr], 1'b0};
        baud_cnt <= '0;
        bit_cnt <= '0;
        state <= TRANSMIT;
      end else begin
        baud_cnt <= (shift || state != TRANSMIT) ? '0 : baud_cnt + 1'b1;
        if (shift) begin
          sh <= {1'b1, sh[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (frame_end) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized bench for uart_tx against a queue/frame-timer model and a serial receiver.
module tb_uart_tx;
  localparam int B = 32;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b0, trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic full, tx_busy, tx_done, TX;
  uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
    .full(full), .tx_busy(tx_busy), .tx_done(tx_done), .TX(TX)
  );
  always #5 clk = ~clk;
  int tests_run = 0, tests_failed = 0;
  int ecnt = 0, s_cyc = 0, mdl_err = 0, err_cyc = 0;
  logic s_tx, s_busy, s_done, s_full;
  logic [3:0] err_got, err_exp;
  logic [7:0] mq[$], sentq[$], rxq[$];
  logic m_busy = 1'b0, m_done = 1'b0;
  int m_ph = 0;
  logic [7:0] m_cur = 8'h00;
  logic rx_on = 1'b0;
  int rx_cnt = 0, rx_ferr = 0;
  logic [7:0] rx_sh = 8'h00;
  // mid-bit sampling receiver at the same bit period
  always @(negedge clk) begin
    if (!rst_n) rx_on <= 1'b0;
    else if (!rx_on) begin
      if (TX == 1'b0) begin
        rx_on <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % B == B / 2) begin
        if (rx_cnt / B >= 1 && rx_cnt / B <= 8) rx_sh[rx_cnt / B - 1] <= TX;
        if (rx_cnt / B == 9) begin
          rx_on <= 1'b0;
          if (TX) rxq.push_back(rx_sh);
          else rx_ferr <= rx_ferr + 1;
        end
      end
    end
  end
  task automatic model_reset;
    mq.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_ph = 0;
  endtask
  // one clock: compare DUT to model mid-cycle, drive inputs, advance the model across the edge
  task automatic tick(input logic t, input logic [7:0] d);
    int k;
    logic e_tx, full_pre;
    @(negedge clk);
    s_tx = TX; s_busy = tx_busy; s_done = tx_done; s_full = full; s_cyc = ecnt;
    k = m_ph / B;
    e_tx = !m_busy ? 1'b1 : k == 0 ? 1'b0 : k == 9 ? 1'b1 : m_cur[k-1];
    if ({s_tx, s_busy, s_done, s_full} !== {e_tx, m_busy, m_done, mq.size() == D}) begin
      if (mdl_err == 0) begin
        err_cyc = ecnt;
        err_got = {s_tx, s_busy, s_done, s_full};
        err_exp = {e_tx, m_busy, m_done, mq.size() == D};
      end
      mdl_err++;
    end
    trmt = t;
    tx_data = d;
    @(posedge clk);
    full_pre = mq.size() == D;
    m_done = 1'b0;
    if (m_busy) begin
      m_ph++;
      if (m_ph == 10 * B) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end
    if (!m_busy && mq.size() != 0) begin
      m_cur = mq.pop_front();
      m_busy = 1'b1;
      m_ph = 0;
    end
    if (t && !full_pre) begin
      mq.push_back(d);
      sentq.push_back(d);
    end
    ecnt++;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests_run++; if (TX !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", TX); end
    tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    tests_run++; if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", tx_done); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
    rst_n = 1'b1;
    model_reset();
    mdl_err = 0;
    repeat (5) tick(1'b0, 8'h00);
    tests_run++; if (mdl_err !== 0) begin tests_failed++; $display("FAIL reset_model: %0d cycles differ, first at %0d got %b expected %b", mdl_err, err_cyc, err_got, err_exp); end
  endtask
  task automatic test_single;
    int t0, c, nd, dc, bad;
    logic [9:0] seq;
    seq = 10'b1101001010;
    rxq.delete(); mdl_err = 0; nd = 0; dc = -1; bad = 0;
    t0 = ecnt;
    for (int i = 0; i <= 340; i++) begin
      tick(i == 0, 8'hA5);
      c = s_cyc - t0;
      if (s_done) begin nd++; dc = c; end
      if (c >= 2 && c < 322 && s_tx !== seq[(c - 2) / B]) bad++;
      if (c == 1) begin tests_run++; if (s_tx !== 1'b1) begin tests_failed++; $display("FAIL single_pre_start: got %b expected 1", s_tx); end end
      if (c == 2) begin tests_run++; if (s_tx !== 1'b0) begin tests_failed++; $display("FAIL single_start_cycle2: got %b expected 0", s_tx); end end
    end
    tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL single_done_count: got %0d expected 1", nd); end
    tests_run++; if (dc !== 322) begin tests_failed++; $display("FAIL single_done_cycle: got %0d expected 322", dc); end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL single_bit_seq: got %0d bad cycles expected 0", bad); end
    tests_run++; if ({s_tx, s_busy} !== 2'b10) begin tests_failed++; $display("FAIL single_after: got tx,busy=%b expected 10", {s_tx, s_busy}); end
    tests_run++; if (rxq.size() !== 1 || rxq[0] !== 8'hA5) begin tests_failed++; $display("FAIL single_rx: got %0d bytes first %h expected 1 byte a5", rxq.size(), rxq.size() ? rxq[0] : 8'h00); end
    tests_run++; if (mdl_err !== 0) begin tests_failed++; $display("FAIL single_model: %0d cycles differ, first at %0d got %b expected %b", mdl_err, err_cyc, err_got, err_exp); end
  endtask
  task automatic test_back_to_back;
    int t0, c, nd, gaps;
    int dcy[3];
    logic [7:0] pat[3];
    pat = '{8'h00, 8'hFF, 8'h55};
    dcy = '{-1, -1, -1};
    rxq.delete(); mdl_err = 0; nd = 0; gaps = 0;
    t0 = ecnt;
    for (int i = 0; i < 1000; i++) begin
      tick(i < 3, pat[i < 3 ? i : 0]);
      c = s_cyc - t0;
      if (s_done) begin if (nd < 3) dcy[nd] = c; nd++; end
      if (c >= 2 && c <= 961 && s_busy !== 1'b1) gaps++;
      if (c == 962) begin tests_run++; if (s_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_fall: got %b expected 0", s_busy); end end
    end
    tests_run++; if (nd !== 3) begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 3", nd); end
    tests_run++; if (dcy[0] !== 322) begin tests_failed++; $display("FAIL b2b_first_done: got %0d expected 322", dcy[0]); end
    tests_run++; if (dcy[1] - dcy[0] !== 320 || dcy[2] - dcy[1] !== 320) begin tests_failed++; $display("FAIL b2b_spacing: got %0d,%0d expected 320,320", dcy[1] - dcy[0], dcy[2] - dcy[1]); end
    tests_run++; if (gaps !== 0) begin tests_failed++; $display("FAIL b2b_busy_gap: got %0d low cycles expected 0", gaps); end
    tests_run++; if (rxq.size() !== 3 || rxq[0] !== 8'h00 || rxq[1] !== 8'hFF || rxq[2] !== 8'h55) begin tests_failed++; $display("FAIL b2b_rx: got %0d bytes expected 00 ff 55", rxq.size()); end
    tests_run++; if (mdl_err !== 0) begin tests_failed++; $display("FAIL b2b_model: %0d cycles differ, first at %0d got %b expected %b", mdl_err, err_cyc, err_got, err_exp); end
  endtask
  task automatic test_overflow;
    int t0, c, fbad, rbad;
    rxq.delete(); mdl_err = 0; fbad = 0; rbad = 0;
    t0 = ecnt;
    for (int i = 0; i < 1800; i++) begin
      tick(i < 6, 8'(i + 1));
      c = s_cyc - t0;
      if (c >= 5 && c <= 321 && s_full !== 1'b1) fbad++;
      if (c == 4) begin tests_run++; if (s_full !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_c4: got %b expected 0", s_full); end end
      if (c == 322) begin tests_run++; if (s_full !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_c322: got %b expected 0", s_full); end end
    end
    for (int i = 0; i < rxq.size(); i++) if (rxq[i] !== 8'(i + 1)) rbad++;
    tests_run++; if (fbad !== 0) begin tests_failed++; $display("FAIL ovf_full_window: got %0d low cycles expected 0", fbad); end
    tests_run++; if (rxq.size() !== 5) begin tests_failed++; $display("FAIL ovf_rx_count: got %0d expected 5", rxq.size()); end
    tests_run++; if (rbad !== 0) begin tests_failed++; $display("FAIL ovf_rx_order: got %0d wrong bytes expected 0", rbad); end
    tests_run++; if (mdl_err !== 0) begin tests_failed++; $display("FAIL ovf_model: %0d cycles differ, first at %0d got %b expected %b", mdl_err, err_cyc, err_got, err_exp); end
  endtask
  task automatic test_simul_push_pop;
    int t0, c, nd;
    logic [7:0] a, b, d;
    a = 8'($urandom); b = 8'($urandom); d = 8'($urandom);
    rxq.delete(); mdl_err = 0; nd = 0;
    t0 = ecnt;
    for (int i = 0; i < 1200; i++) begin
      tick(i == 0 || i == 1 || i == 321, i == 0 ? a : i == 1 ? b : d);
      c = s_cyc - t0;
      if (s_done) nd++;
      if (c == 321) begin tests_run++; if (s_full !== 1'b0) begin tests_failed++; $display("FAIL simul_full: got %b expected 0", s_full); end end
    end
    tests_run++; if (nd !== 3) begin tests_failed++; $display("FAIL simul_done_count: got %0d expected 3", nd); end
    tests_run++; if (rxq.size() !== 3 || rxq[0] !== a || rxq[1] !== b || rxq[2] !== d) begin tests_failed++; $display("FAIL simul_rx: got %0d bytes expected %h %h %h", rxq.size(), a, b, d); end
    tests_run++; if (mdl_err !== 0) begin tests_failed++; $display("FAIL simul_model: %0d cycles differ, first at %0d got %b expected %b", mdl_err, err_cyc, err_got, err_exp); end
  endtask
  task automatic test_reset_mid;
    int t0, c, nd, hi_bad;
    logic [7:0] x;
    x = 8'($urandom) & 8'hF7;
    rxq.delete(); mdl_err = 0; nd = 0; hi_bad = 0; c = 0;
    t0 = ecnt;
    for (int i = 0; c < 140 && i < 200; i++) begin
      tick(i < 3, i == 0 ? x : 8'($urandom));
      c = s_cyc - t0;
    end
    tests_run++; if (s_tx !== 1'b0) begin tests_failed++; $display("FAIL rmid_pre_bit3: got %b expected 0", s_tx); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (TX !== 1'b1) begin tests_failed++; $display("FAIL rmid_tx_async: got %b expected 1", TX); end
    tests_run++; if ({tx_busy, tx_done, full} !== 3'b000) begin tests_failed++; $display("FAIL rmid_flags: got busy,done,full=%b expected 000", {tx_busy, tx_done, full}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 800; i++) begin
      tick(1'b0, 8'h00);
      if (s_done) nd++;
      if (s_tx !== 1'b1) hi_bad++;
    end
    tests_run++; if (nd !== 0) begin tests_failed++; $display("FAIL rmid_no_done: got %0d pulses expected 0", nd); end
    tests_run++; if (hi_bad !== 0) begin tests_failed++; $display("FAIL rmid_idle_tx: got %0d low cycles expected 0", hi_bad); end
    tests_run++; if (rxq.size() !== 0) begin tests_failed++; $display("FAIL rmid_rx: got %0d bytes expected 0", rxq.size()); end
    tests_run++; if (mdl_err !== 0) begin tests_failed++; $display("FAIL rmid_model: %0d cycles differ, first at %0d got %b expected %b", mdl_err, err_cyc, err_got, err_exp); end
  endtask
  task automatic test_loopback;
    int g, bad;
    rxq.delete(); sentq.delete(); mdl_err = 0; g = 0; bad = 0;
    while (sentq.size() < 96 && g < 40000) begin
      tick($urandom_range(0, 3) == 0, 8'($urandom));
      g++;
    end
    g = 0;
    while ((m_busy || mq.size() != 0) && g < 20000) begin
      tick(1'b0, 8'h00);
      g++;
    end
    repeat (4) tick(1'b0, 8'h00);
    for (int i = 0; i < rxq.size() && i < sentq.size(); i++) if (rxq[i] !== sentq[i]) bad++;
    tests_run++; if (rxq.size() !== 96) begin tests_failed++; $display("FAIL loop_rx_count: got %0d expected 96", rxq.size()); end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL loop_rx_data: got %0d wrong bytes expected 0", bad); end
    tests_run++; if (rx_ferr !== 0) begin tests_failed++; $display("FAIL loop_framing: got %0d bad stop bits expected 0", rx_ferr); end
    tests_run++; if (mdl_err !== 0) begin tests_failed++; $display("FAIL loop_model: %0d cycles differ, first at %0d got %b expected %b", mdl_err, err_cyc, err_got, err_exp); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simul_push_pop();
    test_reset_mid();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
